// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter.
//
// Counts rising edges of an asynchronous input over a fixed gate window
// of GATE_CYCLES = CLK_FREQ/GATE_DIV clock cycles. With en held high,
// windows run back to back: GATE_CYCLES counting cycles followed by one
// LATCH cycle, so one result appears every GATE_CYCLES+1 cycles.
//
// Output handshake: valid is a one-cycle pulse with no ready/backpressure.
// freq_out and ovf change only in the cycle valid is high and hold their
// value in between. A consumer must take the result in the valid cycle.
//
// Ports
//   clk_in    in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset
//   en        in   1      level: high = keep measuring, low = stop
//   sig_in    in   1      asynchronous signal under measurement
//   freq_out  out  CNT_W  edges counted in the last completed window
//   valid     out  1      one-cycle pulse when freq_out/ovf update
//   ovf       out  1      last completed window saturated the counter
//   busy      out  1      high whenever the FSM is not idle
//   dbg_state out  2      current FSM state (0 idle, 1 gate, 2 latch)

module freq_meter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int GATE_DIV = 1,
  parameter int CNT_W    = 27
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int GATE_CYCLES = CLK_FREQ / GATE_DIV;
  localparam int GW          = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf_acc;
  logic [CNT_W-1:0] r_freq;
  logic             r_valid;
  logic             r_ovf;
  logic             w_edge;

  // Two flops resolve metastability, the third remembers the previous
  // synchronized level so a rising edge yields exactly one strobe.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_hist;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_acc  <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
          end
        end
        S_GATE: begin
          // Dropping en aborts the window even in its final cycle; the
          // previous result stays on the outputs.
          if (!en) begin
            r_state <= S_IDLE;
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            if (w_edge) begin
              if (r_edge_cnt == CNT_MAX) begin
                r_ovf_acc <= 1'b1;
              end else begin
                r_edge_cnt <= r_edge_cnt + CNT_W'(1);
              end
            end
            if (r_gate_cnt == GATE_LAST) begin
              r_state <= S_LATCH;
            end
          end
        end
        S_LATCH: begin
          // Edge strobes here are ignored; the count is already final.
          r_freq  <= r_edge_cnt;
          r_ovf   <= r_ovf_acc;
          r_valid <= 1'b1;
          if (en) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign freq_out  = r_freq;
  assign valid     = r_valid;
  assign ovf       = r_ovf;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter. Two instances share all inputs: an 8-bit counter
// (never saturates within a 100-cycle window) and a 4-bit counter (saturates
// on busy signals). The reference model logs every sampled sig_in value and
// tracks the bench's gate windows by absolute edge index.

module tb_freq_meter;

  localparam int GC   = 100;
  localparam int LOGN = 20000;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       sig_in;
  logic [7:0] freq8;
  logic       valid8, ovf8, busy8;
  logic [1:0] st8;
  logic [3:0] freq4;
  logic       valid4, ovf4, busy4;
  logic [1:0] st4;

  int checks   = 0;
  int failures = 0;

  // Model state
  int  cyc      = 0;
  int  g        = -1;   // edge index of the current window's first gate edge
  int  acc      = 0;    // true (unsaturated) edge count of current window
  int  last_rst = -1;
  int  held_acc = 0;    // true count behind the currently displayed result
  bit  s_log [LOGN];
  logic [15:0] exp_q[$];

  freq_meter #(.CLK_FREQ(100), .GATE_DIV(1), .CNT_W(8)) dut8 (
    .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(freq8), .valid(valid8), .ovf(ovf8), .busy(busy8),
    .dbg_state(st8)
  );

  freq_meter #(.CLK_FREQ(100), .GATE_DIV(1), .CNT_W(4)) dut4 (
    .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(freq4), .valid(valid4), .ovf(ovf4), .busy(busy4),
    .dbg_state(st4)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  function automatic int sat(int a, int m);
    return (a > m) ? m : a;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // A rising edge sampled at edge k is counted at edge k+2. Samples taken
  // at or before a reset edge read as 0.
  function automatic bit strobe_at(int j);
    int  k;
    bit  cur, prev;
    k    = j - 2;
    cur  = (k > last_rst && k >= 0) ? s_log[k] : 1'b0;
    prev = (k - 1 > last_rst && k >= 1) ? s_log[k-1] : 1'b0;
    return cur & ~prev;
  endfunction

  // Reference model: a window is edges g..g+GC-1; the result appears after
  // edge g+GC. Any en=0 inside the window or rst through g+GC cancels it.
  initial begin
    int j;
    forever begin
      @(posedge clk_in);
      j = cyc;
      if (j < LOGN) s_log[j] = sig_in;
      if (rst) begin
        last_rst = j;
        g        = -1;
        acc      = 0;
        held_acc = 0;
      end else if (g < 0) begin
        if (en) begin
          g   = j + 1;
          acc = 0;
        end
      end else if (j <= g + GC - 1) begin
        if (!en) g = -1;
        else if (strobe_at(j)) acc++;
      end else begin
        exp_q.push_back(16'(acc));
        held_acc = acc;
        if (en) begin
          g   = j + 1;
          acc = 0;
        end else begin
          g = -1;
        end
      end
      cyc = j + 1;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit prev_valid;
    int a;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk_in);
      chk("busy8", int'(busy8), int'(g >= 0));
      chk("busy4", int'(busy4), int'(g >= 0));
      if (prev_valid && valid8) chk("valid_back_to_back", 1, 0);
      if (valid8 || valid4) begin
        chk("valid8_vs_valid4", int'(valid8), int'(valid4));
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", 1, 0);
        end else begin
          a = int'(exp_q.pop_front());
          chk("freq8", int'(freq8), sat(a, 255));
          chk("ovf8",  int'(ovf8),  int'(a > 255));
          chk("freq4", int'(freq4), sat(a, 15));
          chk("ovf4",  int'(ovf4),  int'(a > 15));
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("valid_missing", 0, 1);
          void'(exp_q.pop_front());
        end
        chk("hold_freq8", int'(freq8), sat(held_acc, 255));
        chk("hold_ovf8",  int'(ovf8),  int'(held_acc > 255));
        chk("hold_freq4", int'(freq4), sat(held_acc, 15));
        chk("hold_ovf4",  int'(ovf4),  int'(held_acc > 15));
      end
      prev_valid = valid8;
    end
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic run_toggle(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (i % half == 0) sig_in = ~sig_in;
    end
  endtask

  task automatic run_const(input bit v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      sig_in = 1'($urandom_range(0, 1));
    end
  endtask

  // Wait until the model's gate counter (value held after the last edge)
  // equals n.
  task automatic wait_gc(input int n);
    int budget;
    budget = 400;
    @(negedge clk_in);
    while (!(g >= 0 && cyc - g == n) && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    if (budget == 0) chk("wait_gc_timeout", n, -1);
  endtask

  // Stimulus
  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (5) @(negedge clk_in);
    rst = 1'b0;
    en  = 1'b1;

    // Steady toggling: 10 edges per window.
    run_toggle(5, 3 * (GC + 1) + 5);
    // Fastest toggle saturates the 4-bit counter, then slow toggle clears ovf.
    run_toggle(1, 2 * (GC + 1));
    run_toggle(10, 2 * (GC + 1));
    // Constant levels.
    run_const(1'b0, 2 * (GC + 1));
    run_const(1'b1, 2 * (GC + 1));

    // Abort at gate_cnt 50, idle with activity, then restart.
    sig_in = 1'b0;
    wait_gc(50);
    en = 1'b0;
    run_toggle(2, 20);
    en = 1'b1;
    run_toggle(5, GC + 10);

    // Single edge whose strobe lands in the last gate cycle.
    sig_in = 1'b0;
    wait_gc(5);
    wait_gc(97);
    sig_in = 1'b1;
    // Single edge whose strobe lands in the LATCH cycle.
    wait_gc(5);
    sig_in = 1'b0;
    wait_gc(98);
    sig_in = 1'b1;
    wait_gc(50);
    sig_in = 1'b0;

    // Reset mid-window and in the LATCH cycle.
    run_toggle(5, GC + 50);
    wait_gc(60);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    run_toggle(5, GC + 20);
    wait_gc(100);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;

    // Random signal with random short en drops.
    for (int r = 0; r < 5; r++) begin
      run_rand($urandom_range(150, 320));
      en = 1'b0;
      run_rand($urandom_range(1, 8));
      en = 1'b1;
    end
    run_rand(GC + 20);

    en = 1'b0;
    run_const(1'b0, GC + 20);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
